dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller that sits directly upstream of the 64x8 main-memory RAM.
- Accepts byte read/write requests from the CPU side and serves read hits from an internal line store.
- On a read miss, fills the line from RAM; every write goes through to RAM.
- Drives the RAM's combinational read port and its clocked write port.

Parameters:
- ADDR_W, 6, byte address width; must match RAM depth (64 entries).
- DATA_W, 8, data width.
- INDEX_W, 3, index bits giving 2**INDEX_W lines of one byte each. Tag width TAG_W = ADDR_W - INDEX_W, derived, not overridable.

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high reset
- cpu_req  input  1  request valid, level
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  byte address; index = addr[INDEX_W-1:0], tag = upper bits
- cpu_wdata  input  DATA_W  write data
- cpu_rdata  output  DATA_W  read data, registered, valid while cpu_ready=1
- cpu_ready  output  1  one-cycle completion pulse, registered
- mem_readEn  output  1  RAM read enable
- mem_readAddress  output  ADDR_W  RAM read address
- mem_ReadData  input  DATA_W  RAM combinational read data
- mem_writeEn  output  1  RAM write enable
- mem_writeAddress  output  ADDR_W  RAM write address
- mem_WriteData  output  DATA_W  RAM write data

Behaviour:
- Reset (synchronous, active-high) has priority over all else:
  - state=IDLE; all valid bits=0; cpu_ready=0; cpu_rdata=0; request registers=0.
  - Tag/data arrays are not cleared.
- States: IDLE, LOOKUP, FILL, MEM_WR.
- IDLE: accept when cpu_req=1 and cpu_ready=0. Latch we/addr/wdata into request registers, go to LOOKUP. A request held high across a cpu_ready pulse is re-accepted on the following cycle (one bubble).
- LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
  - Read hit: cpu_rdata<=data[idx], cpu_ready<=1, go to IDLE. Latency 2 edges from request to ready.
  - Read miss: go to FILL.
  - Write hit: data[idx]<=req_wdata, go to MEM_WR.
  - Write miss: line untouched, go to MEM_WR.
- FILL: mem_readEn=1, mem_readAddress=req_addr.
  - At edge: data[idx]<=mem_ReadData, tag[idx]<=req_tag, valid[idx]<=1.
  - Same edge: cpu_rdata<=mem_ReadData, cpu_ready<=1, go to IDLE.
  - An existing line at the index is overwritten; write-through means no writeback is needed.
- MEM_WR: mem_writeEn=1, mem_writeAddress=req_addr, mem_WriteData=req_wdata. At edge: cpu_ready<=1, go to IDLE.
- Latencies: read hit 2 edges, read miss 3, any write 3 (counted from the edge that samples cpu_req to the edge that raises cpu_ready).
- cpu_ready is high for exactly one cycle. cpu_rdata holds its value until the next read completes. Writes leave cpu_rdata unchanged.
- Memory-side enables are decoded from state and gated with !Reset, so Reset asserted mid-FILL or mid-MEM_WR never issues a RAM write in that cycle.
- Outside their states, mem_readEn=0, mem_writeEn=0, and all address/data outputs=0.
- Inputs are ignored outside IDLE. Request registers hold stable for the whole transaction.

Optional Feature:
- Macro DMCACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Each is incremented once per completed LOOKUP; reads and writes both count.
  - Counters saturate at 16'hFFFF and are cleared by Reset.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package cache_pkg:
  - State encoding constants: IDLE=2'd0, LOOKUP=2'd1, FILL=2'd2, MEM_WR=2'd3.
  - Default widths ADDR_W/DATA_W/INDEX_W.
  - Derived TAG_W macro/function.
- One sub-module, dm_cache_lines: holds valid/tag/data arrays with a combinational hit/data lookup port, one synchronous write port, and a synchronous valid-clear on Reset.
- The FSM stays in dm_cache_ctrl.

Test Plan:
- Write 0xA5 to addr 0x2A after reset -> mem_writeEn=1 with writeAddress=0x2A/WriteData=0xA5 for one cycle; cpu_ready pulse 3 edges after request; line 2 still invalid (no allocate).
- Read 0x2A -> miss, FILL with mem_readEn=1 for one cycle; cpu_rdata=0xA5, ready at 3 edges. Repeat read -> hit, ready at 2 edges, mem_readEn stays 0.
- Read 0x0A (same index 2, tag 1) after the above -> miss, fill returns 0x00 and evicts; re-read 0x2A -> miss again, returns 0xA5.
- Write 0x3C to 0x2A while the line is valid -> line updated and RAM written; next read of 0x2A hits, returns 0x3C, ready at 2 edges.
- Assert Reset during the FILL cycle -> no line update, no cpu_ready, state IDLE; following read of the same address misses.
- Hold cpu_req high with back-to-back reads of 0x2A -> one idle cycle between each ready pulse. With DMCACHE_STATS_EN, hit_count and miss_count match the scenario totals.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and defaults for the direct-mapped cache controller slice.
package cache_pkg;

  localparam int unsigned CACHE_ADDR_W  = 6;
  localparam int unsigned CACHE_DATA_W  = 8;
  localparam int unsigned CACHE_INDEX_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  // Tag bits are whatever remains of the byte address above the index.
  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/dm_cache_lines.sv
// Line store: valid/tag/data arrays, combinational lookup, one synchronous write port.
module dm_cache_lines
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = CACHE_INDEX_W,
  parameter int unsigned TAG_W   = tag_width(CACHE_ADDR_W, CACHE_INDEX_W),
  parameter int unsigned DATA_W  = CACHE_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_hit,
  output logic [DATA_W-1:0]  lk_data,
  input  logic               wr_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] data_d [LINES];

  // Lookup of the line selected by the current index.
  always_comb begin
    lk_hit  = valid_q[idx] && (tag_q[idx] == lk_tag);
    lk_data = data_q[idx];
  end

  // A write installs tag and data and marks the line valid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[idx] = 1'b1;
      tag_d[idx]   = wr_tag;
      data_d[idx]  = wr_data;
    end
  end

  // Valid bits are the only line state cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data storage, no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of
// a 64x8 RAM. Optional DMCACHE_STATS_EN adds saturating hit/miss counters.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = CACHE_ADDR_W,
  parameter int unsigned DATA_W  = CACHE_DATA_W,
  parameter int unsigned INDEX_W = CACHE_INDEX_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_readEn,
  output logic [ADDR_W-1:0] mem_readAddress,
  input  logic [DATA_W-1:0] mem_ReadData,
  output logic              mem_writeEn,
  output logic [ADDR_W-1:0] mem_writeAddress,
  output logic [DATA_W-1:0] mem_WriteData
`ifdef DMCACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int unsigned TAG_W = tag_width(ADDR_W, INDEX_W);

  state_e            state_q, state_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;
  logic              line_we;
  logic [DATA_W-1:0] line_wdata;

  dm_cache_lines #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_lines (
    .clk     (Clk),
    .rst     (Reset),
    .idx     (req_addr_q[INDEX_W-1:0]),
    .lk_tag  (req_addr_q[ADDR_W-1:INDEX_W]),
    .lk_hit  (lk_hit),
    .lk_data (lk_data),
    .wr_en   (line_we && !Reset),
    .wr_tag  (req_addr_q[ADDR_W-1:INDEX_W]),
    .wr_data (line_wdata)
  );

  // Next-state, request latching, line updates and completion.
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    line_we     = 1'b0;
    line_wdata  = req_wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req && !cpu_ready_q) begin
          req_we_d    = cpu_we;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!req_we_q) begin
          if (lk_hit) begin
            cpu_rdata_d = lk_data;
            cpu_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = FILL;
          end
        end else begin
          line_we = lk_hit;
          state_d = MEM_WR;
        end
      end
      FILL: begin
        line_we     = 1'b1;
        line_wdata  = mem_ReadData;
        cpu_rdata_d = mem_ReadData;
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end
      MEM_WR: begin
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state and registered CPU-side outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // RAM strobes decode from state; Reset suppresses them so no stray write escapes.
  always_comb begin
    mem_readEn       = (state_q == FILL) && !Reset;
    mem_writeEn      = (state_q == MEM_WR) && !Reset;
    mem_readAddress  = mem_readEn  ? req_addr_q  : '0;
    mem_writeAddress = mem_writeEn ? req_addr_q  : '0;
    mem_WriteData    = mem_writeEn ? req_wdata_q : '0;
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;

`ifdef DMCACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // One count per completed lookup, saturating.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == LOOKUP) begin
      if (lk_hit) begin
        if (hit_count_q != '1) hit_count_d = hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != '1) miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl with a behavioural 64x8 RAM attached.
module tb_dm_cache_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       cpu_req, cpu_we;
  logic [5:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       cpu_ready;
  logic       mem_readEn, mem_writeEn;
  logic [5:0] mem_readAddress, mem_writeAddress;
  logic [7:0] mem_ReadData, mem_WriteData;
`ifdef DMCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  dm_cache_ctrl #(
    .ADDR_W  (6),
    .DATA_W  (8),
    .INDEX_W (3)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_ready        (cpu_ready),
    .mem_readEn       (mem_readEn),
    .mem_readAddress  (mem_readAddress),
    .mem_ReadData     (mem_ReadData),
    .mem_writeEn      (mem_writeEn),
    .mem_writeAddress (mem_writeAddress),
    .mem_WriteData    (mem_WriteData)
`ifdef DMCACHE_STATS_EN
    ,
    .hit_count        (hit_count),
    .miss_count       (miss_count)
`endif
  );

  always #5 Clk = ~Clk;

  // Main-memory RAM: combinational read, clocked write.
  logic [7:0] ram [64];
  assign mem_ReadData = ram[mem_readAddress];
  always @(posedge Clk) if (mem_writeEn) ram[mem_writeAddress] <= mem_WriteData;

  int cycle_cnt = 0;
  always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of outstanding completions.
  typedef struct {
    logic [7:0] rdata;
    int         lat;
    int         start;
  } exp_t;
  exp_t sb[$];
  logic sb_off = 1'b0;

  always @(negedge Clk) begin
    if (!sb_off && cpu_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", cycle_cnt - e.start + 1, e.lat);
        check("cpu_rdata", int'(cpu_rdata), int'(e.rdata));
      end
    end
  end

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       hit;
    logic [7:0] rdata;
  } vec_t;
  vec_t vecs[17];

  logic [7:0] last_rd = 8'h00;
  int exp_hits = 0;
  int exp_misses = 0;

  // One CPU transaction; RAM strobes are observed and checked along the way.
  task automatic run_req(input logic we, input logic [5:0] addr, input logic [7:0] wd,
                         input logic hit, input logic [7:0] rd);
    exp_t e;
    int   rd_cnt;
    int   wr_cnt;
    logic done;
    @(negedge Clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    e.rdata   = we ? last_rd : rd;
    e.lat     = (!we && hit) ? 2 : 3;
    e.start   = cycle_cnt + 1;
    sb.push_back(e);
    if (!we) last_rd = rd;
    if (hit) exp_hits++; else exp_misses++;
    rd_cnt = 0;
    wr_cnt = 0;
    done   = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge Clk);
      // Junk on the inputs after acceptance must not disturb the transaction.
      cpu_req   = 1'b0;
      cpu_we    = 1'($urandom);
      cpu_addr  = 6'($urandom);
      cpu_wdata = 8'($urandom);
      if (mem_readEn) begin
        rd_cnt++;
        check("mem_readAddress", int'(mem_readAddress), int'(addr));
      end
      if (mem_writeEn) begin
        wr_cnt++;
        check("mem_writeAddress", int'(mem_writeAddress), int'(addr));
        check("mem_WriteData", int'(mem_WriteData), int'(wd));
      end
      if (cpu_ready) done = 1'b1;
    end
    check("ready_seen", int'(done), 1);
    check("read_strobe_cycles", rd_cnt, (!we && !hit) ? 1 : 0);
    check("write_strobe_cycles", wr_cnt, we ? 1 : 0);
    @(negedge Clk);
    check("ready_one_cycle", int'(cpu_ready), 0);
  endtask

  initial begin
    int pulses;
    int prev;

    // Scenario table: {we, addr, wdata, hit, read data}.
    vecs[0]  = '{1'b1, 6'h2A, 8'hA5, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 6'h2A, 8'h00, 1'b0, 8'hA5};
    vecs[2]  = '{1'b0, 6'h2A, 8'h00, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 6'h0A, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 6'h2A, 8'h00, 1'b0, 8'hA5};
    vecs[5]  = '{1'b1, 6'h2A, 8'h3C, 1'b1, 8'h00};
    vecs[6]  = '{1'b0, 6'h2A, 8'h00, 1'b1, 8'h3C};
    vecs[7]  = '{1'b0, 6'h0A, 8'h00, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 6'h0A, 8'h77, 1'b1, 8'h00};
    vecs[9]  = '{1'b0, 6'h0A, 8'h00, 1'b1, 8'h77};
    vecs[10] = '{1'b1, 6'h3F, 8'h11, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 6'h3F, 8'h00, 1'b0, 8'h11};
    vecs[12] = '{1'b0, 6'h07, 8'h00, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 6'h2A, 8'h00, 1'b0, 8'h3C};
    vecs[14] = '{1'b1, 6'h00, 8'h5A, 1'b0, 8'h00};
    vecs[15] = '{1'b0, 6'h00, 8'h00, 1'b0, 8'h5A};
    vecs[16] = '{1'b0, 6'h00, 8'h00, 1'b1, 8'h5A};

    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state.
    repeat (3) @(negedge Clk);
    check("rst_cpu_ready", int'(cpu_ready), 0);
    check("rst_cpu_rdata", int'(cpu_rdata), 0);
    check("rst_mem_readEn", int'(mem_readEn), 0);
    check("rst_mem_writeEn", int'(mem_writeEn), 0);
    check("rst_mem_addrs", int'({mem_readAddress, mem_writeAddress, mem_WriteData}), 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_no_ready", int'(cpu_ready), 0);

    for (int i = 0; i < 17; i++)
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hit, vecs[i].rdata);
    check("ram_0x2A", int'(ram[6'h2A]), 8'h3C);

    // Request held high: hits complete every third edge.
    sb_off = 1'b1;
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h00;
    pulses = 0;
    prev   = -1;
    for (int c = 0; c < 30 && pulses < 3; c++) begin
      @(negedge Clk);
      if (cpu_ready) begin
        pulses++;
        check("b2b_rdata", int'(cpu_rdata), 8'h5A);
        if (prev >= 0) check("b2b_gap", cycle_cnt - prev, 3);
        prev = cycle_cnt;
        if (pulses == 3) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    check("b2b_pulses", pulses, 3);
    exp_hits += 3;
    @(negedge Clk);
    check("b2b_stop", int'(cpu_ready), 0);
`ifdef DMCACHE_STATS_EN
    check("hit_count", int'(hit_count), exp_hits);
    check("miss_count", int'(miss_count), exp_misses);
`endif

    // Reset asserted during FILL.
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h15;
    @(negedge Clk);
    cpu_req = 1'b0;
    @(negedge Clk);
    check("fill_readEn", int'(mem_readEn), 1);
    check("fill_readAddress", int'(mem_readAddress), 6'h15);
    Reset = 1'b1;
    #1;
    check("rst_gates_readEn", int'(mem_readEn), 0);
    check("rst_gates_writeEn", int'(mem_writeEn), 0);
    @(negedge Clk);
    check("fill_rst_no_ready", int'(cpu_ready), 0);
    check("fill_rst_rdata", int'(cpu_rdata), 0);
    Reset = 1'b0;
    @(negedge Clk);
    check("fill_rst_still_idle", int'(cpu_ready), 0);
    sb_off = 1'b0;
    last_rd = 8'h00;
    exp_hits = 0;
    exp_misses = 0;
    run_req(1'b0, 6'h15, 8'h00, 1'b0, 8'h00);
    run_req(1'b0, 6'h2A, 8'h00, 1'b0, 8'h3C);
`ifdef DMCACHE_STATS_EN
    check("hit_count_after_rst", int'(hit_count), exp_hits);
    check("miss_count_after_rst", int'(miss_count), exp_misses);
`endif
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
